// File: rtl/regb_fifo_pkg.sv
// Shared constants and width helpers for the register-based show-ahead FIFO.
package regb_fifo_pkg;

  localparam int unsigned REGB_FIFO_DEF_WIDTH = 8;
  localparam int unsigned REGB_FIFO_DEF_DEPTH = 5;

  // Pointer width to address entries 0..n-1.
  function automatic int unsigned regb_fifo_ptr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Count width to hold occupancy 0..n.
  function automatic int unsigned regb_fifo_cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/regb_fifo_ptr.sv
// Wrapping 0..N-1 pointer with increment enable and async active-low reset.
module regb_fifo_ptr
  import regb_fifo_pkg::*;
#(
  parameter int unsigned N  = REGB_FIFO_DEF_DEPTH,
  parameter int unsigned PW = regb_fifo_ptr_w(N)
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PW'(N - 1)) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/regb_fifo.sv
// Register-based synchronous FIFO with show-ahead read port.
// Optional occupancy output enabled by defining REGB_FIFO_LEVEL_EN.
module regb_fifo
  import regb_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = REGB_FIFO_DEF_WIDTH,
  parameter int unsigned N     = REGB_FIFO_DEF_DEPTH
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             shift_out,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
`ifdef REGB_FIFO_LEVEL_EN
  ,
  output logic [regb_fifo_cnt_w(N)-1:0] level
`endif
);

  localparam int unsigned PW = regb_fifo_ptr_w(N);
  localparam int unsigned CW = regb_fifo_cnt_w(N);

  logic [WIDTH-1:0] mem [N];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_d;
  logic             wr_acc;
  logic             rd_acc;

  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign wr_acc = shift_in && (!full || shift_out);
  assign rd_acc = shift_out && !empty;

  regb_fifo_ptr #(.N(N), .PW(PW)) u_wr_ptr (
    .clk   (clk),
    .res_n (res_n),
    .inc   (wr_acc),
    .ptr   (wr_ptr)
  );

  regb_fifo_ptr #(.N(N), .PW(PW)) u_rd_ptr (
    .clk   (clk),
    .res_n (res_n),
    .inc   (rd_acc),
    .ptr   (rd_ptr)
  );

  always_comb begin
    count_d = count;
    if (wr_acc && !rd_acc) begin
      count_d = count + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count - CW'(1);
    end
  end

  // Flags are registered from the next count so they track the count exactly.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      count <= count_d;
      full  <= (count_d == CW'(N));
      empty <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (!empty) begin
      rdata = mem[rd_ptr];
    end
  end

`ifdef REGB_FIFO_LEVEL_EN
  assign level = count;
`endif

endmodule

// File: tb/tb_regb_fifo.sv
// Directed self-checking bench for regb_fifo (default WIDTH=8, N=5).
module tb_regb_fifo;

  logic       clk;
  logic       res_n;
  logic       shift_in;
  logic [7:0] wdata;
  logic       full;
  logic       shift_out;
  logic [7:0] rdata;
  logic       empty;
`ifdef REGB_FIFO_LEVEL_EN
  logic [2:0] level;
`endif

  int n_cmp;
  int n_err;

  regb_fifo #(.WIDTH(8), .N(5)) dut (
    .clk       (clk),
    .res_n     (res_n),
    .shift_in  (shift_in),
    .wdata     (wdata),
    .full      (full),
    .shift_out (shift_out),
    .rdata     (rdata),
    .empty     (empty)
`ifdef REGB_FIFO_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res_n     = 1'b0;
    shift_in  = 1'b0;
    shift_out = 1'b0;
    wdata     = 8'h00;
    for (int t = 0; t < 4; t++) begin
      #25;
      n_cmp++;
      if ({empty, full, rdata} !== {1'b1, 1'b0, 8'h00}) begin
        n_err++;
        $display("FAIL reset t=%0t: empty=%b full=%b rdata=%h, want 1 0 00", $time, empty, full, rdata);
      end
    end
    @(negedge clk);
    res_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    logic [7:0] d [5];
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      shift_in = 1'b1;
      wdata    = d[i];
      step();
      n_cmp++;
      if ({empty, full, rdata} !== {1'b0, (i == 4), 8'h11}) begin
        n_err++;
        $display("FAIL fill[%0d]: empty=%b full=%b rdata=%h, want 0 %b 11", i, empty, full, rdata, (i == 4));
      end
`ifdef REGB_FIFO_LEVEL_EN
      n_cmp++;
      if (level !== 3'(i + 1)) begin
        n_err++;
        $display("FAIL level[%0d]: level=%0d want %0d", i, level, i + 1);
      end
`endif
    end
    wdata = 8'h66;
    step();
    shift_in = 1'b0;
    n_cmp++;
    if ({empty, full, rdata} !== {1'b0, 1'b1, 8'h11}) begin
      n_err++;
      $display("FAIL overfill: empty=%b full=%b rdata=%h, want 0 1 11", empty, full, rdata);
    end
  endtask

  task automatic test_drain(input logic [7:0] first, input logic [7:0] inc);
    logic [7:0] exp;
    for (int i = 0; i < 5; i++) begin
      shift_out = 1'b1;
      step();
      exp = (i == 4) ? 8'h00 : 8'(first + 8'(inc * 8'(i + 1)));
      n_cmp++;
      if ({empty, full, rdata} !== {(i == 4), 1'b0, exp}) begin
        n_err++;
        $display("FAIL drain[%0d]: empty=%b full=%b rdata=%h, want %b 0 %h", i, empty, full, rdata, (i == 4), exp);
      end
    end
    step();
    shift_out = 1'b0;
    n_cmp++;
    if ({empty, full, rdata} !== {1'b1, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL underflow: empty=%b full=%b rdata=%h, want 1 0 00", empty, full, rdata);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin
      shift_in = 1'b1;
      wdata    = 8'(8'h01 + i);
      step();
    end
    shift_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rdata !== 8'(8'h01 + i)) begin
        n_err++;
        $display("FAIL wrap_pre[%0d]: rdata=%h want %h", i, rdata, 8'(8'h01 + i));
      end
      shift_out = 1'b1;
      step();
    end
    shift_out = 1'b0;
    for (int i = 0; i < 5; i++) begin
      shift_in = 1'b1;
      wdata    = 8'(8'hA0 + i);
      step();
    end
    shift_in = 1'b0;
    n_cmp++;
    if ({empty, full, rdata} !== {1'b0, 1'b1, 8'hA0}) begin
      n_err++;
      $display("FAIL wrap_full: empty=%b full=%b rdata=%h, want 0 1 a0", empty, full, rdata);
    end
    test_drain(8'hA0, 8'h01);
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp [5];
    exp = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h77};
    for (int i = 0; i < 5; i++) begin
      shift_in = 1'b1;
      wdata    = 8'(8'hB0 + i);
      step();
    end
    wdata     = 8'h77;
    shift_out = 1'b1;
    step();
    shift_in = 1'b0;
    n_cmp++;
    if ({empty, full, rdata} !== {1'b0, 1'b1, 8'hB1}) begin
      n_err++;
      $display("FAIL simul_full: empty=%b full=%b rdata=%h, want 0 1 b1", empty, full, rdata);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (rdata !== exp[i]) begin
        n_err++;
        $display("FAIL simul_drain[%0d]: rdata=%h want %h", i, rdata, exp[i]);
      end
      step();
    end
    n_cmp++;
    if ({empty, full} !== 2'b10) begin
      n_err++;
      $display("FAIL simul_empty: empty=%b full=%b, want 1 0", empty, full);
    end
    shift_in = 1'b1;
    wdata    = 8'h99;
    step();
    shift_in  = 1'b0;
    shift_out = 1'b0;
    n_cmp++;
    if ({empty, full, rdata} !== {1'b0, 1'b0, 8'h99}) begin
      n_err++;
      $display("FAIL simul_empty_push: empty=%b full=%b rdata=%h, want 0 0 99", empty, full, rdata);
    end
    shift_out = 1'b1;
    step();
    shift_out = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      shift_in = 1'b1;
      wdata    = 8'(8'hC0 + i);
      step();
    end
    shift_in = 1'b0;
    n_cmp++;
    if ({empty, rdata} !== {1'b0, 8'hC0}) begin
      n_err++;
      $display("FAIL pre_reset: empty=%b rdata=%h, want 0 c0", empty, rdata);
    end
    #2;
    res_n = 1'b0;
    #1;
    n_cmp++;
    if ({empty, full, rdata} !== {1'b1, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL async_reset: empty=%b full=%b rdata=%h, want 1 0 00", empty, full, rdata);
    end
    #1;
    res_n = 1'b1;
    step();
    n_cmp++;
    if ({empty, full, rdata} !== {1'b1, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL post_reset: empty=%b full=%b rdata=%h, want 1 0 00", empty, full, rdata);
    end
    shift_in = 1'b1;
    wdata    = 8'h5A;
    step();
    shift_in = 1'b0;
    n_cmp++;
    if ({empty, rdata} !== {1'b0, 8'h5A}) begin
      n_err++;
      $display("FAIL post_reset_push: empty=%b rdata=%h, want 0 5a", empty, rdata);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fill();
    test_drain(8'h11, 8'h11);
    test_wrap();
    test_simultaneous();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
